// File: rtl/demux5_stage_pkg.sv
// rtl/demux5_stage_pkg.sv - shared port count, select encoding and sink index names for the 5-way demux
package demux5_stage_pkg;

    localparam int DMX_PORTS = 5;
    localparam int DMX_SEL_W = 3;

    // Same encoding as the 5-way result select mux on the gather side.
    typedef enum logic [DMX_SEL_W-1:0] {
        DMX_P0 = 3'd0,
        DMX_P1 = 3'd1,
        DMX_P2 = 3'd2,
        DMX_P3 = 3'd3,
        DMX_P4 = 3'd4
    } dmx_port_e;

    function automatic logic is_legal_sel(input logic [DMX_SEL_W-1:0] sel);
        return sel <= DMX_SEL_W'(DMX_PORTS - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear; clear and increment together yield one
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/demux5_stage.sv
// rtl/demux5_stage.sv - registered 1-to-5 demux with valid/ready, one holding entry and illegal-select drop counting
module demux5_stage
    import demux5_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [DMX_SEL_W-1:0] in_sel,
    output logic [DMX_PORTS-1:0] out_valid,
    input  logic [DMX_PORTS-1:0] out_ready,
    output logic [WIDTH-1:0]     y0,
    output logic [WIDTH-1:0]     y1,
    output logic [WIDTH-1:0]     y2,
    output logic [WIDTH-1:0]     y3,
    output logic [WIDTH-1:0]     y4,
    output logic                 err,
    output logic [CNT_W-1:0]     drop_cnt,
    input  logic                 err_clr
);

    logic                 full_q;
    logic [WIDTH-1:0]     data_q;
    logic [DMX_SEL_W-1:0] sel_q;
    logic                 sel_ready;
    logic                 drain;
    logic                 accept;
    logic                 legal;

    // Only the selected sink's ready matters; the others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        out_valid = '0;
        for (int i = 0; i < DMX_PORTS; i++) begin
            if (sel_q == DMX_SEL_W'(i)) begin
                sel_ready    = out_ready[i];
                out_valid[i] = full_q;
            end
        end
    end

    assign in_ready = !full_q || sel_ready;
    assign drain    = full_q && sel_ready;
    assign accept   = in_valid && in_ready;
    assign legal    = is_legal_sel(in_sel);

    assign y0 = out_valid[0] ? data_q : '0;
    assign y1 = out_valid[1] ? data_q : '0;
    assign y2 = out_valid[2] ? data_q : '0;
    assign y3 = out_valid[3] ? data_q : '0;
    assign y4 = out_valid[4] ? data_q : '0;

    // An illegal word is swallowed: it never touches data_q/sel_q, it only lets a drain empty the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
            err    <= 1'b0;
        end else begin
            if (accept && legal) begin
                full_q <= 1'b1;
                data_q <= in_data;
                sel_q  <= in_sel;
            end else if (drain) begin
                full_q <= 1'b0;
            end

            if (accept && !legal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (accept && !legal),
        .clr  (err_clr),
        .q    (drop_cnt)
    );

endmodule

// File: tb/tb_demux5_stage.sv
// tb/tb_demux5_stage.sv - vector table plus scoreboard bench for demux5_stage
module tb_demux5_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic [4:0] out_valid;
    logic [4:0] out_ready;
    logic [7:0] y0, y1, y2, y3, y4;
    logic       err;
    logic [7:0] drop_cnt;
    logic       err_clr;

    logic [7:0] yv [5];
    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;
    assign yv[4] = y4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [2:0] sel;
        logic [7:0] d;
        logic [4:0] ordy;
        logic [4:0] eov;
        logic [7:0] ey;
        logic       eir;
    } vec_t;

    vec_t tbl [12];

    typedef struct {
        logic [2:0] sel;
        logic [7:0] d;
    } sb_t;

    sb_t        sb [$];
    logic       m_err;
    logic [7:0] m_cnt;

    demux5_stage #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y4       (y4),
        .err      (err),
        .drop_cnt (drop_cnt),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic [4:0] eov, input logic [7:0] ey,
                               input logic eir);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(eir));
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s.y%0d", tag, i), 32'(yv[i]), eov[i] ? 32'(ey) : 32'd0);
    endtask

    // Scoreboard: pop on every sink handshake, push on every legal accept, track err/drop_cnt.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            m_err = 1'b0;
            m_cnt = 8'd0;
        end else begin
            chk("sb.err", 32'(err), 32'(m_err));
            chk("sb.drop_cnt", 32'(drop_cnt), 32'(m_cnt));
            for (int i = 0; i < 5; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("sb.unexpected_y%0d", i), 32'(yv[i]), 32'hDEAD);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        chk("sb.port", i, 32'(e.sel));
                        chk("sb.data", 32'(yv[i]), 32'(e.d));
                    end
                end
            end
            if (in_valid && in_ready && in_sel <= 3'd4) begin
                sb.push_back('{in_sel, in_data});
                if (err_clr) begin
                    m_err = 1'b0;
                    m_cnt = 8'd0;
                end
            end else if (in_valid && in_ready) begin
                m_err = 1'b1;
                m_cnt = err_clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
            end else if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 8'd0;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 3'd0;
        out_ready = 5'h1F;
        err_clr   = 1'b0;

        //        v     sel   data   ordy   eov       ey     eir
        tbl[0]  = '{1'b1, 3'd2, 8'hA5, 5'h1F, 5'b00000, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 3'd0, 8'h00, 5'h1F, 5'b00100, 8'hA5, 1'b1};
        tbl[2]  = '{1'b1, 3'd0, 8'h01, 5'h1F, 5'b00000, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 3'd1, 8'h02, 5'h1F, 5'b00001, 8'h01, 1'b1};
        tbl[4]  = '{1'b1, 3'd2, 8'h03, 5'h1F, 5'b00010, 8'h02, 1'b1};
        tbl[5]  = '{1'b1, 3'd3, 8'h04, 5'h1F, 5'b00100, 8'h03, 1'b1};
        tbl[6]  = '{1'b1, 3'd4, 8'h05, 5'h1F, 5'b01000, 8'h04, 1'b1};
        tbl[7]  = '{1'b0, 3'd0, 8'h00, 5'h1F, 5'b10000, 8'h05, 1'b1};
        tbl[8]  = '{1'b0, 3'd0, 8'h00, 5'h1F, 5'b00000, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, 3'd0, 8'h77, 5'h1F, 5'b00000, 8'h00, 1'b1};
        tbl[10] = '{1'b1, 3'd5, 8'hEE, 5'h1F, 5'b00001, 8'h77, 1'b1};
        tbl[11] = '{1'b0, 3'd0, 8'h00, 5'h1F, 5'b00000, 8'h00, 1'b1};

        step();
        step();
        @(negedge clk);
        chk_outputs("reset", 5'b00000, 8'h00, 1'b1);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);
        step();
        reset = 1'b0;

        // Single word, streaming across all ports, then drain coinciding with an illegal word.
        for (int k = 0; k < 12; k++) begin
            in_valid  = tbl[k].v;
            in_sel    = tbl[k].sel;
            in_data   = tbl[k].d;
            out_ready = tbl[k].ordy;
            @(negedge clk);
            chk_outputs($sformatf("vec%0d", k), tbl[k].eov, tbl[k].ey, tbl[k].eir);
            step();
        end
        chk("vec.drop_after_drain_illegal", 32'(drop_cnt), 32'd1);

        // Stall on port 3 while a second word waits.
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 8'h3C;
        out_ready = 5'b10111;
        step();
        in_sel  = 3'd1;
        in_data = 8'h11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_outputs($sformatf("stall%0d", c), 5'b01000, 8'h3C, 1'b0);
            step();
        end
        out_ready = 5'h1F;
        @(negedge clk);
        chk_outputs("release", 5'b01000, 8'h3C, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk_outputs("after_release", 5'b00010, 8'h11, 1'b1);
        step();

        // Illegal selects: sticky error, saturation, clear-then-count.
        err_clr = 1'b1;
        step();
        err_clr  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 3'd6;
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk_outputs("illegal1", 5'b00000, 8'h00, 1'b1);
        chk("illegal1.err", 32'(err), 32'd1);
        chk("illegal1.drop_cnt", 32'(drop_cnt), 32'd1);
        step();
        in_valid = 1'b1;
        for (int c = 0; c < 300; c++) step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("saturate.drop_cnt", 32'(drop_cnt), 32'hFF);
        chk("saturate.out_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b1;
        err_clr  = 1'b1;
        step();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        chk("clr_and_illegal.drop_cnt", 32'(drop_cnt), 32'd1);
        chk("clr_and_illegal.err", 32'(err), 32'd1);
        step();

        // Reset while holding a stalled word for port 4.
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_data   = 8'h5A;
        out_ready = 5'b00000;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk_outputs("full_p4", 5'b10000, 8'h5A, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 5'h1F;
        @(negedge clk);
        chk_outputs("mid_reset", 5'b00000, 8'h00, 1'b1);
        chk("mid_reset.err", 32'(err), 32'd0);
        chk("mid_reset.drop_cnt", 32'(drop_cnt), 32'd0);
        step();
        step();

        chk("sb.leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
